switch_reader: RTL and testbench

SWITCH_READER -- requirements
Module: switch_reader

---
 rtl/switch_reader_pkg.sv | 10 +
 rtl/switch_debounce_bit.sv | 67 ++++++
 rtl/switch_reader.sv | 65 ++++++
 tb/tb_switch_reader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/switch_reader_pkg.sv
// Shared constants and debounce FSM encoding for the switch reader.
package switch_reader_pkg;
    localparam int DB_COUNT_DEF = 50000;
    localparam int CNT_W        = 16;

    typedef enum logic {
        DB_IDLE     = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;
endpackage

// File: rtl/switch_debounce_bit.sv
// One switch: two-flop synchronizer feeding an IDLE/COUNTING debounce FSM.
module switch_debounce_bit
    import switch_reader_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_stable
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

    logic             r_sync1, r_sync2, r_stable, w_stable_nxt;
    db_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_state  <= DB_IDLE;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_sw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        case (r_state)
            DB_IDLE: begin
                w_cnt_nxt = '0;
                if (r_sync2 != r_stable) begin
                    w_state_nxt = DB_COUNTING;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            DB_COUNTING: begin
                if (r_sync2 == r_stable) begin
                    // glitch: drop the partial count, keep the old level
                    w_state_nxt = DB_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_stable_nxt = r_sync2;
                    w_state_nxt  = DB_IDLE;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = DB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_stable = r_stable;
endmodule

// File: rtl/switch_reader.sv
// Debounced switch bank with edge pulses, sticky change flags, irq and a read port.
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter int NUM_SW   = 4,
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SW-1:0]   switches,
    output logic [NUM_SW-1:0]   sw_state,
    output logic [NUM_SW-1:0]   sw_rise,
    output logic [NUM_SW-1:0]   sw_fall,
    output logic                irq,
    input  logic                rd_req,
    output logic                rd_valid,
    output logic [2*NUM_SW-1:0] rd_data
);
    logic [NUM_SW-1:0]   w_stable, w_edge, w_clr, w_chg_nxt;
    logic [NUM_SW-1:0]   r_sw_state, r_rise, r_fall, r_changed;
    logic                r_irq, r_rd_valid;
    logic [2*NUM_SW-1:0] r_rd_data;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
        switch_debounce_bit #(.DB_COUNT(DB_COUNT)) u_db (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_sw     (switches[g]),
            .o_stable (w_stable[g])
        );
    end

    // A read clears only what it reports; a fresh edge in the same cycle is kept.
    assign w_edge    = w_stable ^ r_sw_state;
    assign w_clr     = rd_req ? r_changed : '0;
    assign w_chg_nxt = (r_changed & ~w_clr) | w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_state <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_changed  <= '0;
            r_irq      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_sw_state <= w_stable;
            r_rise     <= w_stable & ~r_sw_state;
            r_fall     <= ~w_stable & r_sw_state;
            r_changed  <= w_chg_nxt;
            r_irq      <= |w_chg_nxt;
            r_rd_valid <= rd_req;
            if (rd_req)
                r_rd_data <= {r_changed, r_sw_state};
        end
    end

    assign sw_state = r_sw_state;
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;
    assign irq      = r_irq;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
endmodule

// File: tb/tb_switch_reader.sv
// Directed vector bench for switch_reader with DB_COUNT=4, NUM_SW=4.
module tb_switch_reader;
    localparam int NUM_SW   = 4;
    localparam int DB_COUNT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] switches = 4'h0;
    logic       rd_req = 1'b0;
    logic [3:0] sw_state, sw_rise, sw_fall;
    logic       irq, rd_valid;
    logic [7:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    switch_reader #(.NUM_SW(NUM_SW), .DB_COUNT(DB_COUNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .switches (switches),
        .sw_state (sw_state),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .irq      (irq),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sw;
        logic        rd;
        logic [21:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    // {state, rise, fall, irq, rd_valid, rd_data}
    function automatic logic [21:0] mk(input logic [3:0] st, input logic [3:0] ri,
                                       input logic [3:0] fa, input logic iq,
                                       input logic vl, input logic [7:0] dt);
        return {st, ri, fa, iq, vl, dt};
    endfunction

    function automatic vec_t row(input logic [3:0] sw, input logic rd,
                                 input logic [21:0] exp, input string name);
        vec_t v;
        v.sw = sw; v.rd = rd; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] act;
        act = {sw_state, sw_rise, sw_fall, irq, rd_valid, rd_data};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%h ri=%h fa=%h irq=%b vld=%b dat=%h, want st=%h ri=%h fa=%h irq=%b vld=%b dat=%h",
                     name, act[21:18], act[17:14], act[13:10], act[9], act[8], act[7:0],
                     exp[21:18], exp[17:14], exp[13:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic step(input logic [3:0] sw, input logic rd, input logic [21:0] exp,
                        input string name);
        switches = sw;
        rd_req   = rd;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    initial begin
        // rise on bit 0 after DB_COUNT+2 edges, then reads
        for (int i = 0; i < 6; i++) tbl.push_back(row(4'h1, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00), $sformatf("rise0_wait%0d", i)));
        tbl.push_back(row(4'h1, 1'b0, mk(4'h1, 4'h1, 4'h0, 1, 0, 8'h00), "rise0_pulse"));
        tbl.push_back(row(4'h1, 1'b0, mk(4'h1, 4'h0, 4'h0, 1, 0, 8'h00), "rise0_after"));
        tbl.push_back(row(4'h1, 1'b1, mk(4'h1, 4'h0, 4'h0, 0, 1, 8'h11), "read1"));
        tbl.push_back(row(4'h1, 1'b1, mk(4'h1, 4'h0, 4'h0, 0, 1, 8'h01), "read2_b2b"));
        tbl.push_back(row(4'h1, 1'b0, mk(4'h1, 4'h0, 4'h0, 0, 0, 8'h01), "rd_hold"));
        // 2-cycle glitch on bit 1 must be filtered
        tbl.push_back(row(4'h3, 1'b0, mk(4'h1, 4'h0, 4'h0, 0, 0, 8'h01), "glitch_hi0"));
        tbl.push_back(row(4'h3, 1'b0, mk(4'h1, 4'h0, 4'h0, 0, 0, 8'h01), "glitch_hi1"));
        for (int i = 0; i < 8; i++) tbl.push_back(row(4'h1, 1'b0, mk(4'h1, 4'h0, 4'h0, 0, 0, 8'h01), $sformatf("glitch_lo%0d", i)));
        // fall on bit 0
        for (int i = 0; i < 6; i++) tbl.push_back(row(4'h0, 1'b0, mk(4'h1, 4'h0, 4'h0, 0, 0, 8'h01), $sformatf("fall0_wait%0d", i)));
        tbl.push_back(row(4'h0, 1'b0, mk(4'h0, 4'h0, 4'h1, 1, 0, 8'h01), "fall0_pulse"));
        tbl.push_back(row(4'h0, 1'b1, mk(4'h0, 4'h0, 4'h0, 0, 1, 8'h10), "read_fall"));
        tbl.push_back(row(4'h0, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h10), "rd_hold2"));

        // reset state
        #2;
        check("reset_state", mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(4'h0, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00), "idle");

        foreach (tbl[i]) step(tbl[i].sw, tbl[i].rd, tbl[i].exp, tbl[i].name);

        // debounced edge coinciding with a read: read misses it, flag survives
        for (int i = 0; i < 6; i++) step(4'h4, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h10), "race_wait");
        step(4'h4, 1'b1, mk(4'h4, 4'h4, 4'h0, 1, 1, 8'h00), "race_read");
        step(4'h4, 1'b1, mk(4'h4, 4'h0, 4'h0, 0, 1, 8'h44), "race_reread");
        step(4'h4, 1'b0, mk(4'h4, 4'h0, 4'h0, 0, 0, 8'h44), "race_hold");

        // reset with switches high, re-reset mid-count
        @(negedge clk);
        rst = 1'b1; switches = 4'hF; rd_req = 1'b0;
        #1;
        check("rst_async_clear", mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00));
        for (int i = 0; i < 2; i++) step(4'hF, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00), "in_reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(4'hF, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00), "count_partial");
        rst = 1'b1;
        #1;
        check("rst_mid_count", mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00));
        for (int i = 0; i < 2; i++) step(4'hF, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00), "in_reset2");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(4'hF, 1'b0, mk(4'h0, 4'h0, 4'h0, 0, 0, 8'h00), $sformatf("rel_wait%0d", i));
        step(4'hF, 1'b0, mk(4'hF, 4'hF, 4'h0, 1, 0, 8'h00), "rel_rise");
        step(4'hF, 1'b0, mk(4'hF, 4'h0, 4'h0, 1, 0, 8'h00), "rel_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
